// File: rtl/md_pkg.sv
// Shared definitions for the position-cell read path.
//  POS_WIDTH : width of one coordinate
//  state_t   : cell streamer sequencer states
//  pos_t     : one RAM position word, {posz, posy, posx}
package md_pkg;

  localparam int POS_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [POS_WIDTH-1:0] posz;
    logic [POS_WIDTH-1:0] posy;
    logic [POS_WIDTH-1:0] posx;
  } pos_t;

endpackage

// File: rtl/pos_skid_fifo.sv
// Small synchronous FIFO with a registered head entry.
//  clock, rst_n : clock, async active-low reset
//  push, wdata  : write one entry (caller guarantees not full)
//  pop          : consume head when rvalid
//  rvalid/rdata : registered head entry
//  occ          : entries held, including the head
// A push into an empty FIFO shows on rdata the following cycle; the head
// only changes on a pop or while empty, so it holds under back-pressure.
module pos_skid_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [PW:0]      occ
);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [PW:0]      held, occ_n;
  logic             pop_ok;

  assign pop_ok   = pop && rvalid;
  assign rd_ptr_n = rd_ptr + PW'(pop_ok);
  // entries that stay in the ring after this cycle's pop, before the push
  assign held     = occ - (PW+1)'(pop_ok);
  assign occ_n    = held + (PW+1)'(push);

  always_ff @(posedge clock) begin
    if (push) ram[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      occ    <= occ_n;
      rvalid <= (occ_n != '0);
      // next head is either the word being written now (ring otherwise
      // empty) or the stored entry at the advanced read pointer
      if (held == '0) begin
        if (push) rdata <= wdata;
      end else begin
        rdata <= ram[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/pos_cell_streamer.sv
// Read-side sequencer for one position cell RAM.
// Reads the count word (address 0), then particle words 1..count, and
// streams {pos, pid, last} to the force pipeline over valid/ready.
//  clock, rst_n     : clock, async active-low reset
//  start            : begin a scan (ignored unless idle)
//  busy, done       : scan in progress / 1-cycle completion pulse
//  particle_count   : clamped count from word 0
//  count_err        : raw count exceeded PARTICLE_NUM-1 (sticky to next start)
//  mem_addr/rden/wren, mem_q : RAM read port, 2-cycle read latency
//  out_valid/ready/pos/pid/last : particle stream
module pos_cell_streamer
  import md_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_PID = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] PID_ONE = ADDR_WIDTH'(1);

  state_t                         state;
  logic                           wait_cnt;
  logic [ADDR_WIDTH-1:0]          next_addr;
  logic [1:0]                     rd_vld;   // read tag shift register
  logic [1:0][ADDR_WIDTH-1:0]     rd_pid;   // pid travelling with each tag
  logic [ADDR_WIDTH-1:0]          raw_cnt, clamped, issue_pid;
  logic                           cnt_over, cnt_hit;
  logic                           first_issue, stream_issue, issue;
  logic                           credit_ok, drain_done;
  logic [OCC_W-1:0]               occ, inflight;
  logic [ENT_W-1:0]               fifo_wdata, fifo_rdata;

  assign mem_wren = 1'b0;

  // count word sits on mem_q in the second WAIT_CNT cycle
  assign raw_cnt  = mem_q[ADDR_WIDTH-1:0];
  assign cnt_hit  = (state == WAIT_CNT) && wait_cnt;
  assign cnt_over = raw_cnt > MAX_PID;
  assign clamped  = cnt_over ? MAX_PID : raw_cnt;

  // Credits: a read goes out only while landed-but-unpopped plus
  // in-flight words leave room in the FIFO, so a push never overflows.
  assign inflight  = OCC_W'(rd_vld[0]) + OCC_W'(rd_vld[1]);
  assign credit_ok = ({1'b0, inflight} + {1'b0, occ}) < (OCC_W+1)'(FIFO_DEPTH);

  // Particle 1 is read in the same cycle the count lands (decoded straight
  // from mem_q) so the first word reaches the output 6 cycles after start.
  // Issue is decoded combinationally so credits see this cycle's occupancy.
  assign first_issue  = cnt_hit && (raw_cnt != '0);
  assign stream_issue = (state == STREAM) && credit_ok;
  assign issue        = first_issue || stream_issue;
  assign issue_pid    = stream_issue ? next_addr : PID_ONE;

  assign mem_rden = (state == RD_CNT) || issue;

  always_comb begin
    mem_addr = '0;
    if (stream_issue)     mem_addr = next_addr;
    else if (first_issue) mem_addr = PID_ONE;
  end

  // finished once nothing is in flight and the FIFO empties this cycle
  assign drain_done = (rd_vld == 2'b00) &&
                      ((occ == '0) || ((occ == OCC_W'(1)) && out_valid && out_ready));

  assign fifo_wdata = {mem_q, rd_pid[1], (rd_pid[1] == particle_count)};
  assign {out_pos, out_pid, out_last} = fifo_rdata;

  pos_skid_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .rst_n  (rst_n),
    .push   (rd_vld[1]),
    .wdata  (fifo_wdata),
    .pop    (out_ready),
    .rvalid (out_valid),
    .rdata  (fifo_rdata),
    .occ    (occ)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= 1'b0;
      next_addr      <= '0;
      rd_vld         <= '0;
      rd_pid         <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= {rd_vld[0], issue};
      rd_pid <= {rd_pid[0], issue_pid};
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_CNT;
            busy      <= 1'b1;
            count_err <= 1'b0;
          end
        end
        RD_CNT: begin
          state    <= WAIT_CNT;
          wait_cnt <= 1'b0;
        end
        WAIT_CNT: begin
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else begin
            particle_count <= clamped;
            count_err      <= cnt_over;
            if (raw_cnt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (clamped == PID_ONE) begin
              state <= DRAIN;  // the only read already went out
            end else begin
              state     <= STREAM;
              next_addr <= ADDR_WIDTH'(2);
            end
          end
        end
        STREAM: begin
          if (stream_issue) begin
            next_addr <= next_addr + 1'b1;
            if (next_addr == particle_count) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_cell_streamer.sv
// Randomized bench for pos_cell_streamer with a 2-cycle RAM model and a
// scoreboard derived from the scan rules (pids 1..min(raw,219), in order).
module tb_pos_cell_streamer;
  import md_pkg::*;

  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, count_err;
  logic [AW-1:0] particle_count, mem_addr, out_pid;
  logic          mem_rden, mem_wren;
  logic [DW-1:0] mem_q = '0;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_pos;

  int n_tests = 0;
  int n_fail  = 0;

  pos_cell_streamer #(
    .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .count_err(count_err),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
    .out_pid(out_pid), .out_last(out_last)
  );

  always #5 clock = ~clock;

  // RAM model: data appears on mem_q two cycles after the rden cycle
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_r1 = '0;
  always @(posedge clock) begin
    if (mem_rden) ram_r1 <= ram[mem_addr];
    mem_q <= ram_r1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 99) < 30);
      default: return !(t >= 9 && t <= 18);
    endcase
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({busy, done, particle_count, count_err, mem_addr, mem_rden,
                 mem_wren, out_valid, out_pos, out_pid, out_last});
  endfunction

  // raw: count word; mode: ready pattern; dup: cycle of an extra start
  // (-1 none); rst_pid: assert reset when this pid is presented (0 none)
  task automatic run_scan(input int raw, input int mode, input int dup,
                          input int rst_pid, input bit fixed_pos);
    int n, t, nacc, issued, maxaddr, first_v, last_acc, done_t;
    bit hold, prev_busy;
    logic [DW-1:0] w, h_pos;
    logic [AW-1:0] h_pid;
    logic h_last;
    pos_t p;
    n = (raw > PN-1) ? PN-1 : raw;
    w = {$urandom(), $urandom(), $urandom()};
    w[7:0] = 8'(raw);
    ram[0] = w;
    for (int i = 1; i < 256; i++) begin
      p = '{posz: $urandom(), posy: $urandom(), posx: $urandom()};
      ram[i] = fixed_pos ? DW'(i * 32'h111) : p;
    end
    t = 0; nacc = 0; issued = 0; maxaddr = 0;
    first_v = -1; last_acc = -1; done_t = -1;
    hold = 0; prev_busy = 0;
    h_pos = '0; h_pid = '0; h_last = 0;
    @(negedge clock);
    while (done_t < 0 && t < 3000) begin
      start = (t == 0) || (t == dup);
      out_ready = rdy(mode, t);
      if (rst_pid > 0 && out_valid && int'(out_pid) == rst_pid) begin
        rst_n = 1'b0;
        #1;
        chk("reset_abort", all_outs(), 128'd0);
        start = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        return;
      end
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", {out_pos, out_pid, out_last}, {h_pos, h_pid, h_last});
      end
      if (mem_rden) begin
        chk("addr_bound", (int'(mem_addr) <= n), 1'b1);
        chk("wren", mem_wren, 1'b0);
        if (mem_addr != 0) issued++;
        if (int'(mem_addr) > maxaddr) maxaddr = int'(mem_addr);
        chk("outstanding", ((issued - nacc) <= FD), 1'b1);
      end
      if (mode == 2 && t == 18 && n >= 12) begin
        chk("stall_rden", mem_rden, 1'b0);
        chk("stall_fill", issued - nacc, FD);
      end
      if (out_valid && first_v < 0) first_v = t;
      if (out_valid && out_ready) begin
        nacc++;
        chk("pid", out_pid, nacc);
        if (nacc < 256) chk("pos", out_pos, ram[nacc]);
        chk("last", out_last, (nacc == n));
        last_acc = t;
      end
      hold = out_valid && !out_ready;
      h_pos = out_pos; h_pid = out_pid; h_last = out_last;
      if (t == 1) chk("busy_on", busy, 1'b1);
      if (done) begin
        done_t = t;
        chk("busy_at_done", busy, 1'b0);
        chk("busy_before_done", prev_busy, 1'b1);
      end
      prev_busy = busy;
      if (done_t < 0) begin
        @(negedge clock);
        t++;
      end
    end
    start = 1'b0;
    if (done_t < 0) begin
      chk("timeout", 1'b0, 1'b1);
      return;
    end
    chk("n_accepted", nacc, n);
    chk("done_time", done_t, (n == 0) ? 4 : last_acc + 1);
    chk("particle_count", particle_count, n);
    chk("count_err", count_err, (raw > PN-1));
    chk("max_addr", maxaddr, n);
    if (n == 0) chk("no_valid", (first_v < 0), 1'b1);
    if (mode == 0 && n > 0) begin
      chk("first_valid", first_v, 6);
      chk("throughput", last_acc, 5 + n);
    end
    @(negedge clock);
    chk("done_pulse", done, 1'b0);
    chk("busy_off", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    repeat (2) @(negedge clock);
    chk("reset_state", all_outs(), 128'd0);
    rst_n = 1'b1;
    @(negedge clock);

    run_scan(3,   0, -1, 0, 1'b1);   // basic latency/ordering
    run_scan(0,   0, -1, 0, 1'b0);   // empty cell
    run_scan(20,  1, -1, 0, 1'b0);   // random back-pressure
    run_scan(250, 0, -1, 0, 1'b0);   // oversize count clamps to 219
    run_scan(10,  0,  7, 0, 1'b0);   // start while busy is ignored
    run_scan(10,  0, -1, 5, 1'b0);   // reset mid-scan
    run_scan(10,  0, -1, 0, 1'b0);   // fresh scan after abort
    run_scan(20,  2, -1, 0, 1'b0);   // 10-cycle stall mid-stream
    run_scan(1,   1, -1, 0, 1'b0);   // single particle
    run_scan(220, 1, -1, 0, 1'b0);   // first over-range count
    for (int k = 0; k < 4; k++) run_scan($urandom_range(1, 40), 1, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
